// File: rtl/dcache_nway_pkg.sv
// rtl/dcache_nway_pkg.sv - shared types, line geometry and helper functions for dcache_nway
package dcache_nway_pkg;

  localparam int LINE_W     = 256;
  localparam int OFFSET_W   = 5;
  localparam int WORD_SEL_W = 3;
  localparam int MAX_WAYS   = 16;
  localparam int MAX_LEVELS = 4;

  typedef enum logic [1:0] {IDLE, WB, FILL} state_e;

  typedef struct packed {
    logic [MAX_WAYS-2:0] mask;
    logic [MAX_WAYS-2:0] val;
  } plru_upd_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return res;
  endfunction

  // Tree is heap-ordered: node n lives at bit n-1, children are 2n and 2n+1.
  function automatic int plru_victim(input logic [MAX_WAYS-2:0] tree, input int levels);
    int n = 1;
    for (int l = 0; l < MAX_LEVELS; l++) begin
      if (l < levels) begin
        n = 2*n + (tree[n-1] ? 1 : 0);
      end
    end
    return n - (1 << levels);
  endfunction

  function automatic plru_upd_t plru_update_masks(input int way, input int levels);
    plru_upd_t res;
    int n = 1;
    int d;
    res = '0;
    for (int l = 0; l < MAX_LEVELS; l++) begin
      if (l < levels) begin
        d = (way >> (levels - 1 - l)) & 1;
        res.mask[n-1] = 1'b1;
        res.val[n-1]  = (d == 0);
        n = 2*n + d;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_nway_plru_tree.sv
// rtl/dcache_nway_plru_tree.sv - combinational tree pseudo-LRU: victim pick and post-access update
module plru_tree
  import dcache_nway_pkg::*;
#(
  parameter int WAYS = 4
) (
  input  logic [WAYS-2:0]         i_tree,
  input  logic [$clog2(WAYS)-1:0] i_way,
  output logic [WAYS-2:0]         o_tree_next,
  output logic [$clog2(WAYS)-1:0] o_victim
);

  localparam int WAY_W = $clog2(WAYS);

  logic [MAX_WAYS-2:0] w_tree_wide;
  logic [MAX_WAYS-2:0] w_next_wide;
  plru_upd_t           w_upd;

  assign w_tree_wide = (MAX_WAYS-1)'(i_tree);
  assign w_upd       = plru_update_masks(int'(i_way), WAY_W);
  assign w_next_wide = (w_tree_wide & ~w_upd.mask) | (w_upd.val & w_upd.mask);
  assign o_tree_next = (WAYS-1)'(w_next_wide);
  assign o_victim    = WAY_W'(plru_victim(w_tree_wide, WAY_W));

endmodule

// File: rtl/dcache_nway.sv
// rtl/dcache_nway.sv - N-way write-back, write-allocate L1 data cache with PLRU and hit/miss counters
module dcache_nway
  import dcache_nway_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int SETS  = 8,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [3:0]        mem_byte_enable,
  input  logic [31:0]       mem_address,
  input  logic [31:0]       mem_wdata,
  output logic              mem_resp,
  output logic [31:0]       mem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata,
  output logic              if_miss,
  output logic              miss_sig,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - OFFSET_W - IDX_W;
  localparam int WAY_W = $clog2(WAYS);

  logic [TAG_W-1:0]  r_tag   [WAYS][SETS];
  logic [LINE_W-1:0] r_data  [WAYS][SETS];
  logic [WAYS-1:0]   r_valid [SETS];
  logic [WAYS-1:0]   r_dirty [SETS];
  logic [WAYS-2:0]   r_plru  [SETS];
  state_e            r_state;
  logic [WAY_W-1:0]  r_victim;
  logic              r_pmem_read;
  logic              r_pmem_write;
  logic [31:0]       r_pmem_addr;
  logic [CNT_W-1:0]  r_hit_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;

  logic [IDX_W-1:0]      w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic [WORD_SEL_W-1:0] w_word;
  logic [31:0]           w_line_addr;
  logic                  w_req;
  logic [WAYS-1:0]       w_hit_vec;
  logic [WAY_W-1:0]      w_hit_way;
  logic [WAY_W-1:0]      w_first_inv;
  logic                  w_has_inv;
  logic                  w_hit;
  logic [WAY_W-1:0]      w_plru_victim;
  logic [WAYS-2:0]       w_plru_next;
  logic [WAY_W-1:0]      w_victim;
  logic                  w_resp;
  logic                  w_miss;
  logic                  w_unused;

  assign w_idx       = mem_address[OFFSET_W +: IDX_W];
  assign w_tag       = mem_address[31 -: TAG_W];
  assign w_word      = mem_address[2 +: WORD_SEL_W];
  assign w_line_addr = {w_tag, w_idx, 5'b0};
  assign w_req       = rst_n & (mem_read | mem_write);
  assign w_unused    = ^mem_address[1:0];

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    w_hit_vec   = '0;
    w_hit_way   = '0;
    w_first_inv = '0;
    w_has_inv   = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_idx][w] && (r_tag[w][w_idx] == w_tag)) begin
        w_hit_vec[w] = 1'b1;
        w_hit_way    = WAY_W'(w);
      end
      if (!r_valid[w_idx][w]) begin
        w_has_inv   = 1'b1;
        w_first_inv = WAY_W'(w);
      end
    end
  end

  assign w_hit    = $onehot(w_hit_vec);
  assign w_victim = w_has_inv ? w_first_inv : w_plru_victim;
  assign w_resp   = (r_state == IDLE) && w_req && w_hit;
  assign w_miss   = (r_state == IDLE) && w_req && !w_hit;

  plru_tree #(.WAYS(WAYS)) u_plru (
    .i_tree      (r_plru[w_idx]),
    .i_way       (w_hit_way),
    .o_tree_next (w_plru_next),
    .o_victim    (w_plru_victim)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_victim     <= '0;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
      r_pmem_addr  <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else begin
      if (cnt_clr) begin
        r_hit_cnt  <= '0;
        r_miss_cnt <= '0;
      end else begin
        if (w_resp && (r_hit_cnt != '1))   r_hit_cnt  <= r_hit_cnt + CNT_W'(1);
        if (w_miss && (r_miss_cnt != '1))  r_miss_cnt <= r_miss_cnt + CNT_W'(1);
      end
      case (r_state)
        IDLE: begin
          if (w_resp) begin
            r_plru[w_idx] <= w_plru_next;
            if (mem_write) r_dirty[w_idx][w_hit_way] <= 1'b1;
          end else if (w_miss) begin
            r_victim <= w_victim;
            if (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) begin
              r_state      <= WB;
              r_pmem_write <= 1'b1;
              r_pmem_addr  <= {r_tag[w_victim][w_idx], w_idx, 5'b0};
            end else begin
              r_state     <= FILL;
              r_pmem_read <= 1'b1;
              r_pmem_addr <= w_line_addr;
            end
          end
        end
        WB: begin
          if (pmem_resp) begin
            r_state      <= FILL;
            r_pmem_write <= 1'b0;
            r_pmem_read  <= 1'b1;
            r_pmem_addr  <= w_line_addr;
          end
        end
        FILL: begin
          if (pmem_resp) begin
            r_state                  <= IDLE;
            r_pmem_read              <= 1'b0;
            r_valid[w_idx][r_victim] <= 1'b1;
            r_dirty[w_idx][r_victim] <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Tag and data storage carry no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (w_resp && mem_write) begin
      r_data[w_hit_way][w_idx][{w_word, 5'b0} +: 32] <=
        merge_bytes(r_data[w_hit_way][w_idx][{w_word, 5'b0} +: 32], mem_wdata, mem_byte_enable);
    end
    if ((r_state == FILL) && pmem_resp) begin
      r_data[r_victim][w_idx] <= pmem_rdata;
      r_tag[r_victim][w_idx]  <= w_tag;
    end
  end

  assign mem_resp     = w_resp;
  assign mem_rdata    = r_data[w_hit_way][w_idx][{w_word, 5'b0} +: 32];
  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_pmem_addr;
  assign pmem_wdata   = r_data[r_victim][w_idx];
  assign if_miss      = w_miss;
  assign miss_sig     = r_pmem_read;
  assign hit_count    = r_hit_cnt;
  assign miss_count   = r_miss_cnt;

endmodule

// File: doc/dcache_nway.md
Name: dcache_nway

Overview:
- Parametrised successor to the current 2-way data cache: N-way set-associative, write-back, write-allocate L1 data cache.
- Sits between the pipeline MEM stage and the arbiter/physical-memory port.
- Adds:
  - configurable way and set counts
  - tree pseudo-LRU replacement
  - invalid-way-first victim selection
  - saturating hit/miss performance counters with clear
- Keeps the existing prefetcher hooks (if_miss, miss_sig).

Parameters:
- WAYS, 4, associativity; power of 2, range 2..16.
- SETS, 8, number of sets; power of 2, range 2..256.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_read  in  1  CPU read request; held until mem_resp.
- mem_write  in  1  CPU write request; held until mem_resp.
- mem_byte_enable  in  4  write byte mask.
- mem_address  in  32  byte address; bits [1:0] ignored.
- mem_wdata  in  32  write data.
- mem_resp  out  1  request complete.
- mem_rdata  out  32  read data, valid when mem_resp is high.
- pmem_read  out  1  line fill request.
- pmem_write  out  1  line write-back request.
- pmem_address  out  32  line address; bits [4:0] are 0.
- pmem_wdata  out  256  victim line.
- pmem_resp  in  1  memory done.
- pmem_rdata  in  256  fill line.
- if_miss  out  1  one-cycle pulse on miss detection.
- miss_sig  out  1  equals pmem_read.
- cnt_clr  in  1  synchronous clear of both counters.
- hit_count  out  CNT_W  saturating count of hits.
- miss_count  out  CNT_W  saturating count of misses.

Behaviour:
- Address fields:
  - offset = addr[4:0]
  - index = addr[4+IDX_W:5], where IDX_W = log2(SETS)
  - tag = the remaining upper bits
  - word select = addr[4:2]
- Reset (asynchronous, while rst_n=0):
  - state=IDLE.
  - All valid, dirty and PLRU bits = 0.
  - Counters = 0.
  - mem_resp, pmem_read, pmem_write, if_miss = 0; pmem_address=0.
  - Tag and data arrays are not reset.
- Reset during a pmem transaction: the transaction is abandoned and pmem_read/pmem_write drop immediately. The memory side must tolerate this.
- Request priority: mem_read and mem_write high together is treated as a write.
- Lookup: tag and valid compare across all ways is combinational in IDLE. Hit = exactly one way with valid and a matching tag.
- IDLE:
  - Idle with no request: all handshake outputs stay 0.
  - On a hit: mem_resp=1 in the same cycle (0-cycle hit latency).
    - Read hit: mem_rdata = the selected word.
    - Write hit: bytes with mem_byte_enable=1 are merged into the selected word at the clock edge and the line's dirty bit is set.
    - The PLRU tree for the set is updated to point away from the hit way.
    - hit_count increments.
  - On a miss:
    - Victim = lowest-index invalid way; if all ways are valid, the PLRU victim.
    - if_miss pulses for 1 cycle and miss_count increments once.
    - Next state is WB if the victim is valid and dirty, else FILL.
- WB:
  - pmem_write=1.
  - pmem_address = {victim tag, index, 5'b0}.
  - pmem_wdata = victim line.
  - On pmem_resp, go to FILL.
- FILL:
  - pmem_read=1, pmem_address = {req tag, index, 5'b0}.
  - On pmem_resp: write pmem_rdata into the victim way, set the new tag, valid=1, dirty=0; go to IDLE.
  - The request then hits in IDLE. Miss latency = WB + FILL + 1 IDLE cycle.
  - A hit that follows a miss counts as a hit as well.
- Victim way is latched on entry to WB/FILL and held constant through both states.
- PLRU tree:
  - WAYS-1 bits per set; bit=0 means the victim is on the left side.
  - On an access, the bits along the accessed path are set to point away from that way.
  - PLRU is updated only on hit responses.
- Counters:
  - Saturate at all-ones.
  - cnt_clr has priority over increment in the same cycle.
- mem_resp is never asserted outside IDLE.
- A request that drops before mem_resp is protocol-illegal; behaviour is undefined.

Decomposition:
- Package dcache_nway_pkg:
  - LINE_W=256, OFFSET_W=5, WORD_SEL_W=3.
  - state enum {IDLE, WB, FILL}.
  - Function for the byte-merge.
  - Function for the PLRU victim and update masks.
- One sub-module plru_tree #(WAYS), combinational:
  - Inputs: tree bits, access way.
  - Outputs: next tree bits, victim way.
- FSM and arrays live in dcache_nway.

Test Plan (WAYS=4, SETS=8):
1. Cold read miss: after reset, read 0x0000_0040.
   - Expect: if_miss pulse, pmem_read=1, pmem_address=0x40.
   - Return pmem_resp with word0=0xDEADBEEF; next cycle mem_resp=1 with mem_rdata=0xDEADBEEF.
   - Counters: miss_count=1, hit_count=1.
2. Write hit merge: after case 1, write 0x40 with wdata 0x11223344, be=4'b0011.
   - Expect: mem_resp in the same cycle.
   - Read 0x40 -> 0xDEAD3344.
3. Fill then evict:
   - Fill set 2 with reads of 0x040, 0x140, 0x240, 0x340 (ways 0..3), then write 0x040.
   - Read 0x440. Expect: PLRU victim = way 0 is not chosen if it was just used; the first-touched non-recent way is evicted.
   - If the victim is dirty: pmem_write with the victim address precedes pmem_read at 0x440.
4. Dirty eviction exact check:
   - Write 0x040, then touch 0x140, 0x240, 0x340, then read 0x440.
   - Expect: pmem_write at 0x040, then pmem_read at 0x440, with the written word visible in pmem_wdata.
5. Reset mid-fill: assert rst_n=0 while pmem_read=1.
   - Expect: pmem_read=0 asynchronously.
   - After release, a read of 0x40 misses again.
6. Counter saturation and clear (CNT_W=4):
   - 20 hits -> hit_count=15.
   - cnt_clr together with a hit -> 0.
